// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// instruction-fetch port and the load/store port, with a bounded wait.
// Note: rst_n is active-high (1 = reset) and asynchronous.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          owner,
    output logic          busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TIME_LIM   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg,   state_next;
    logic            m_req_reg,   m_req_next;
    logic            m_we_reg,    m_we_next;
    logic [AW-1:0]   m_addr_reg,  m_addr_next;
    logic [DW-1:0]   m_wdata_reg, m_wdata_next;
    logic            owner_reg,   owner_next;
    logic [SW-1:0]   starve_reg,  starve_next;
    logic [TW-1:0]   timer_reg,   timer_next;
    logic [1:0]      ack_reg,     ack_next;
    logic [DW-1:0]   rdata_reg,   rdata_next;
    logic            err_reg,     err_next;
    logic            fetch_wins;
    logic [DW-1:0]   rdata_sel [2];

    // Data has priority unless fetch has been passed over STARVE_MAX times in a row.
    assign fetch_wins = if_req && (!d_req || (starve_reg == STARVE_LIM));

    always_comb begin
        state_next   = state_reg;
        m_req_next   = m_req_reg;
        m_we_next    = m_we_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        owner_next   = owner_reg;
        starve_next  = starve_reg;
        timer_next   = timer_reg;
        ack_next     = '0;
        rdata_next   = '0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (fetch_wins) begin
                    state_next   = XFER;
                    m_req_next   = 1'b1;
                    m_we_next    = 1'b0;
                    m_addr_next  = if_addr;
                    m_wdata_next = '0;
                    owner_next   = 1'b0;
                    starve_next  = '0;
                end else if (d_req) begin
                    state_next   = XFER;
                    m_req_next   = 1'b1;
                    m_we_next    = d_we;
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    owner_next   = 1'b1;
                    if (!if_req) begin
                        starve_next = '0;
                    end else if (starve_reg != STARVE_LIM) begin
                        starve_next = starve_reg + 1'b1;
                    end
                end
            end
            XFER: begin
                if (m_ack) begin
                    state_next          = RESP;
                    m_req_next          = 1'b0;
                    ack_next[owner_reg] = 1'b1;
                    rdata_next          = m_rdata;
                end else if (timer_reg == TIME_LIM) begin
                    // Memory never answered: complete with an error and no data.
                    state_next          = RESP;
                    m_req_next          = 1'b0;
                    ack_next[owner_reg] = 1'b1;
                    err_next            = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RESP: begin
                state_next   = IDLE;
                m_req_next   = 1'b0;
                m_we_next    = 1'b0;
                m_addr_next  = '0;
                m_wdata_next = '0;
                owner_next   = 1'b0;
                timer_next   = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            owner_reg   <= 1'b0;
            starve_reg  <= '0;
            timer_reg   <= '0;
            ack_reg     <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            m_req_reg   <= m_req_next;
            m_we_reg    <= m_we_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            owner_reg   <= owner_next;
            starve_reg  <= starve_next;
            timer_reg   <= timer_next;
            ack_reg     <= ack_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
        end
    end

    // Read data is only visible on the requester currently being acknowledged.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rdata_sel[gi] = ack_reg[gi] ? rdata_reg : '0;
        end
    endgenerate

    assign if_ack   = ack_reg[0];
    assign d_ack    = ack_reg[1];
    assign if_rdata = rdata_sel[0];
    assign d_rdata  = rdata_sel[1];
    assign err      = err_reg;
    assign m_req    = m_req_reg;
    assign m_we     = m_we_reg;
    assign m_addr   = m_addr_reg;
    assign m_wdata  = m_wdata_reg;
    assign owner    = owner_reg;
    assign busy     = (state_reg != IDLE);

endmodule
